// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master sequencer: state encoding, counter
// width and the tick-counter width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_TRAIL,
    S_DONE
  } state_t;

  localparam int CNT_W = 4;

  function automatic int tick_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/spi_div_tick.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and flags the final cycle
// of the current phase. restart forces the count back to zero.
module spi_div_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic last
);

  localparam int TW = tick_w(CLK_DIV);

  logic [TW-1:0] tick;

  assign last = (tick == TW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || restart) tick <= '0;
    else                   tick <= tick + TW'(1);
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer driving an external 4-bit descending bit counter.
// state | meaning
// IDLE  | waiting for start, cs_n high
// LOAD  | cs_n low, first bit on mosi, sclk low
// HIGH  | sclk high, miso captured on entry
// LOW   | sclk low, next bit on mosi
// TRAIL | sclk low after last bit, cs_n still low
// DONE  | cs_n high, rx_data updated, done pulse
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic              cnt_sel,
  output logic              cnt_ena,
  output logic [CNT_W-1:0]  cnt_datos,
  input  logic              cnt_zero
);

  state_t            state;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              last;
  logic              restart;

  // Every phase ends on last, so the tick counter is restarted whenever the
  // state is about to change or is parked in IDLE/DONE.
  assign restart   = (state == S_IDLE) || (state == S_DONE) || last;
  assign cnt_datos = CNT_W'(DATA_W - 1);

  spi_div_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      cnt_sel <= 1'b0;
      cnt_ena <= 1'b0;
    end else begin
      cnt_sel <= 1'b0;
      cnt_ena <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          tx_sh   <= tx_data;
          rx_sh   <= '0;
          mosi    <= tx_data[DATA_W-1];
          cnt_sel <= 1'b1;
          cs_n    <= 1'b0;
          busy    <= 1'b1;
          state   <= S_LOAD;
        end
        S_LOAD, S_LOW: if (last) begin
          sclk  <= 1'b1;
          rx_sh <= {rx_sh[DATA_W-2:0], miso};
          state <= S_HIGH;
        end
        S_HIGH: if (last) begin
          sclk <= 1'b0;
          // The counter reaches zero only after the final bit's decrement.
          if (cnt_zero) begin
            state <= S_TRAIL;
          end else begin
            cnt_ena <= 1'b1;
            tx_sh   <= tx_sh << 1;
            mosi    <= tx_sh[DATA_W-2];
            state   <= S_LOW;
          end
        end
        S_TRAIL: if (last) begin
          cs_n    <= 1'b1;
          rx_data <= rx_sh;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: two instances (8-bit/div 2 and
// 16-bit/div 1), each with a behavioural model of the external bit counter.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic rst_n;
  logic loop, miso_fix, use_b;

  logic        a_start, a_busy, a_done, a_sclk, a_mosi, a_miso, a_cs_n, a_sel, a_ena, a_zero;
  logic [7:0]  a_tx, a_rx;
  logic [3:0]  a_datos;
  logic [3:0]  a_cnt = 4'd9;

  logic        b_start, b_busy, b_done, b_sclk, b_mosi, b_miso, b_cs_n, b_sel, b_ena, b_zero;
  logic [15:0] b_tx, b_rx;
  logic [3:0]  b_datos;
  logic [3:0]  b_cnt = 4'd6;

  assign a_miso = loop ? a_mosi : miso_fix;
  assign b_miso = loop ? b_mosi : miso_fix;

  // External descending counter: acts on the falling edge of clk.
  always @(negedge clk) begin
    if (a_sel) a_cnt <= a_datos;
    else if (a_ena) a_cnt <= a_cnt - 4'd1;
    if (b_sel) b_cnt <= b_datos;
    else if (b_ena) b_cnt <= b_cnt - 4'd1;
  end
  assign a_zero = (a_cnt == 4'd0);
  assign b_zero = (b_cnt == 4'd0);

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .tx_data(a_tx), .rx_data(a_rx),
    .busy(a_busy), .done(a_done), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso),
    .cs_n(a_cs_n), .cnt_sel(a_sel), .cnt_ena(a_ena), .cnt_datos(a_datos), .cnt_zero(a_zero)
  );

  spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .tx_data(b_tx), .rx_data(b_rx),
    .busy(b_busy), .done(b_done), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso),
    .cs_n(b_cs_n), .cnt_sel(b_sel), .cnt_ena(b_ena), .cnt_datos(b_datos), .cnt_zero(b_zero)
  );

  // Measurements of the last transfer run by run_xfer.
  int          r_rises, r_sels, r_enas, r_overlap, r_cs_low, r_busy_hi;
  int          r_done_cnt, r_done_at, r_cs_hi_tail;
  logic [15:0] r_mbits, r_rx;
  logic        r_timeout;

  // Must be called just after a falling edge with the selected DUT idle.
  // Sample idx k is the cycle following the k-th rising edge after acceptance.
  task automatic run_xfer(input logic [15:0] tx, input int ign1, input int ign2, input int stop_rise);
    int   w;
    logic ps, s_sclk, s_mosi, s_cs, s_sel, s_ena, s_busy, s_done, s;
    logic [15:0] s_rx;
    w = use_b ? 16 : 8;
    ps = 1'b0;
    r_rises = 0; r_sels = 0; r_enas = 0; r_overlap = 0; r_cs_low = 0; r_busy_hi = 0;
    r_done_cnt = 0; r_done_at = -1; r_cs_hi_tail = 0; r_mbits = '0; r_rx = '0; r_timeout = 1'b1;
    a_tx = tx[7:0]; b_tx = tx;
    a_start = !use_b; b_start = use_b;
    for (int idx = 0; idx < 120; idx++) begin
      @(negedge clk);
      s_sclk = use_b ? b_sclk : a_sclk;
      s_mosi = use_b ? b_mosi : a_mosi;
      s_cs   = use_b ? b_cs_n : a_cs_n;
      s_sel  = use_b ? b_sel  : a_sel;
      s_ena  = use_b ? b_ena  : a_ena;
      s_busy = use_b ? b_busy : a_busy;
      s_done = use_b ? b_done : a_done;
      s_rx   = use_b ? b_rx   : {8'h00, a_rx};
      if (s_sclk && !ps) begin
        if (r_rises < w) r_mbits[w-1-r_rises] = s_mosi;
        r_rises++;
      end
      ps = s_sclk;
      if (s_sel) r_sels++;
      if (s_ena) r_enas++;
      if (s_sel && s_ena) r_overlap++;
      if (!s_cs) r_cs_low++;
      if (s_busy) r_busy_hi++;
      if (s_done) begin
        r_done_cnt++;
        if (r_done_at < 0) begin r_done_at = idx; r_rx = s_rx; end
      end
      if (r_done_at >= 0 && s_cs) r_cs_hi_tail++;
      if (idx == 0) begin a_tx = ~tx[7:0]; b_tx = ~tx; end
      if ((stop_rise > 0 && r_rises == stop_rise) || (r_done_at >= 0 && idx == r_done_at + 1)) begin
        a_start = 1'b0; b_start = 1'b0; r_timeout = 1'b0;
        break;
      end
      s = (idx == ign1) || (idx == ign2);
      a_start = s & !use_b;
      b_start = s & use_b;
    end
    a_start = 1'b0; b_start = 1'b0;
  endtask

  task automatic test_reset_state();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (a_cs_n !== 1'b1) begin failures++; $display("FAIL por_cs_n got=%b exp=1", a_cs_n); end
    if (a_sclk !== 1'b0) begin failures++; $display("FAIL por_sclk got=%b exp=0", a_sclk); end
    if (a_mosi !== 1'b0) begin failures++; $display("FAIL por_mosi got=%b exp=0", a_mosi); end
    if (a_busy !== 1'b0) begin failures++; $display("FAIL por_busy got=%b exp=0", a_busy); end
    if (a_done !== 1'b0) begin failures++; $display("FAIL por_done got=%b exp=0", a_done); end
    if (a_rx !== 8'h00) begin failures++; $display("FAIL por_rx got=%h exp=00", a_rx); end
    if (a_sel !== 1'b0 || a_ena !== 1'b0) begin failures++; $display("FAIL por_cnt_ctl got=%b%b exp=00", a_sel, a_ena); end
    if (a_datos !== 4'd7) begin failures++; $display("FAIL por_datos got=%0d exp=7", a_datos); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    use_b = 1'b0; loop = 1'b1;
    run_xfer(16'h00A5, -1, -1, 0);
    checks += 9;
    if (r_timeout) begin failures++; $display("FAIL lb_timeout got=1 exp=0"); end
    if (r_mbits[7:0] !== 8'hA5) begin failures++; $display("FAIL lb_mosi_bits got=%h exp=a5", r_mbits[7:0]); end
    if (r_rises != 8) begin failures++; $display("FAIL lb_sclk_rises got=%0d exp=8", r_rises); end
    if (r_sels != 1) begin failures++; $display("FAIL lb_cnt_sel got=%0d exp=1", r_sels); end
    if (r_enas != 7) begin failures++; $display("FAIL lb_cnt_ena got=%0d exp=7", r_enas); end
    if (r_overlap != 0) begin failures++; $display("FAIL lb_sel_ena_overlap got=%0d exp=0", r_overlap); end
    if (r_done_at != 34 || r_done_cnt != 1) begin failures++; $display("FAIL lb_done got_at=%0d cnt=%0d exp_at=34 cnt=1", r_done_at, r_done_cnt); end
    if (r_rx[7:0] !== 8'hA5) begin failures++; $display("FAIL lb_rx got=%h exp=a5", r_rx[7:0]); end
    if (r_busy_hi != 35) begin failures++; $display("FAIL lb_busy_cycles got=%0d exp=35", r_busy_hi); end
  endtask

  task automatic test_receive_only();
    use_b = 1'b0; loop = 1'b0; miso_fix = 1'b1;
    run_xfer(16'h0000, -1, -1, 0);
    checks += 4;
    if (r_mbits[7:0] !== 8'h00) begin failures++; $display("FAIL rx_only_mosi got=%h exp=00", r_mbits[7:0]); end
    if (r_rx[7:0] !== 8'hFF) begin failures++; $display("FAIL rx_only_rx got=%h exp=ff", r_rx[7:0]); end
    if (r_cs_low != 34) begin failures++; $display("FAIL rx_only_cs_low got=%0d exp=34", r_cs_low); end
    if (r_done_at != 34) begin failures++; $display("FAIL rx_only_done_at got=%0d exp=34", r_done_at); end
  endtask

  task automatic test_reset();
    int dones;
    use_b = 1'b0; loop = 1'b1;
    run_xfer(16'h0066, -1, -1, 2);
    rst_n = 1'b0;
    dones = 0;
    @(negedge clk);
    checks += 6;
    if (a_cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", a_cs_n); end
    if (a_sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", a_sclk); end
    if (a_mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", a_mosi); end
    if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
    if (a_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", a_done); end
    if (a_rx !== 8'h00) begin failures++; $display("FAIL rst_rx got=%h exp=00", a_rx); end
    repeat (2) begin @(negedge clk); if (a_done) dones++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (a_done) dones++; end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_back_to_back();
    int idle_busy;
    use_b = 1'b0; loop = 1'b1;
    run_xfer(16'h005A, 5, 20, 0);
    checks += 3;
    if (r_done_cnt != 1 || r_done_at != 34) begin failures++; $display("FAIL b2b_ignored_start got_cnt=%0d at=%0d exp_cnt=1 at=34", r_done_cnt, r_done_at); end
    if (r_sels != 1) begin failures++; $display("FAIL b2b_sel_once got=%0d exp=1", r_sels); end
    // cs_n stays high for the DONE cycle plus the single IDLE cycle before reload.
    if (r_cs_hi_tail != 2) begin failures++; $display("FAIL b2b_cs_gap got=%0d exp=2", r_cs_hi_tail); end
    run_xfer(16'h00C3, 34, -1, 0);
    checks += 2;
    if (r_done_at != 34 || r_cs_low != 34) begin failures++; $display("FAIL b2b_second got_at=%0d cs_low=%0d exp_at=34 cs_low=34", r_done_at, r_cs_low); end
    if (r_rx[7:0] !== 8'hC3) begin failures++; $display("FAIL b2b_rx got=%h exp=c3", r_rx[7:0]); end
    idle_busy = 0;
    repeat (4) begin @(negedge clk); if (a_busy || !a_cs_n) idle_busy++; end
    checks++;
    if (idle_busy != 0) begin failures++; $display("FAIL b2b_start_in_done got=%0d exp=0", idle_busy); end
  endtask

  task automatic test_abort_recovery();
    int dones;
    use_b = 1'b0; loop = 1'b1;
    run_xfer(16'h0096, -1, -1, 3);
    rst_n = 1'b0;
    dones = 0;
    repeat (3) begin @(negedge clk); if (a_done) dones++; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (a_done) dones++; end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    run_xfer(16'h003C, -1, -1, 0);
    checks += 3;
    if (r_rx[7:0] !== 8'h3C) begin failures++; $display("FAIL abort_recover_rx got=%h exp=3c", r_rx[7:0]); end
    if (r_rises != 8 || r_enas != 7) begin failures++; $display("FAIL abort_recover_shape got_rises=%0d enas=%0d exp=8/7", r_rises, r_enas); end
    if (r_done_at != 34) begin failures++; $display("FAIL abort_recover_done_at got=%0d exp=34", r_done_at); end
  endtask

  task automatic test_edge_params();
    use_b = 1'b1; loop = 1'b1;
    checks++;
    if (b_datos !== 4'd15) begin failures++; $display("FAIL edge_datos got=%0d exp=15", b_datos); end
    run_xfer(16'h8001, -1, -1, 0);
    checks += 6;
    if (r_rises != 16) begin failures++; $display("FAIL edge_sclk_rises got=%0d exp=16", r_rises); end
    if (r_enas != 15) begin failures++; $display("FAIL edge_cnt_ena got=%0d exp=15", r_enas); end
    if (r_sels != 1 || r_overlap != 0) begin failures++; $display("FAIL edge_cnt_sel got=%0d overlap=%0d exp=1/0", r_sels, r_overlap); end
    if (r_done_at != 33) begin failures++; $display("FAIL edge_done_at got=%0d exp=33", r_done_at); end
    if (r_rx !== 16'h8001) begin failures++; $display("FAIL edge_rx got=%h exp=8001", r_rx); end
    if (r_mbits !== 16'h8001) begin failures++; $display("FAIL edge_mosi_bits got=%h exp=8001", r_mbits); end
  endtask

  initial begin
    rst_n = 1'b0; loop = 1'b1; miso_fix = 1'b0; use_b = 1'b0;
    a_start = 1'b0; b_start = 1'b0; a_tx = '0; b_tx = '0;
    @(negedge clk);
    test_reset_state();
    test_loopback();
    test_receive_only();
    test_reset();
    test_back_to_back();
    test_abort_recovery();
    test_edge_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
